board_io_ctrl: RTL

- Parametrised board-side I/O controller between the core's memory-mapped I/O words and the DE2 pins.
- Registers and optionally hex-decodes N seven-segment channels.
- Debounces switch inputs.
- Replaces raw LCD bit-banging with a timed write sequencer that uses a valid/ready handshake.

---
 rtl/board_io_pkg.sv | 25 ++
 rtl/hex_seg_decode.sv | 14 +
 rtl/board_io_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/board_io_pkg.sv
// Shared types and constants for the board I/O controller.
package board_io_pkg;

    // LCD write sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        EN_HI = 2'd2,
        HOLD  = 2'd3
    } lcd_state_e;

    // All segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Control bits inside each memory-mapped hex word.
    localparam int HEX_DECODE_BIT = 31;
    localparam int HEX_BLANK_BIT  = 30;

    // Active-low glyphs 0..F, segment order {g,f,e,d,c,b,a}.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low seven-segment glyph.
module hex_seg_decode
    import board_io_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Table lookup of the glyph for the nibble.
    always_comb begin
        o_seg = HEX_GLYPH[i_nibble];
    end

endmodule

// File: rtl/board_io_ctrl.sv
// Board-side I/O controller: hex displays, LEDs, debounced switches and a
// timed LCD write sequencer with a valid/ready request port.
//
// Handshake: a request is taken on a rising edge where i_lcd_valid and
// o_lcd_ready are both high; the requester must hold i_lcd_rs/i_lcd_byte with
// valid until then, and values offered while ready is low are not looked at.
module board_io_ctrl
    import board_io_pkg::*;
#(
    parameter int NUM_HEX       = 8,
    parameter int NUM_SW        = 17,
    parameter int NUM_LEDR      = 17,
    parameter int NUM_LEDG      = 8,
    parameter int DB_CYC        = 50000,
    parameter int LCD_SETUP_CYC = 4,
    parameter int LCD_EN_CYC    = 12,
    parameter int LCD_HOLD_CYC  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [NUM_SW-1:0]     i_sw_raw,
    output logic [NUM_SW-1:0]     o_sw_db,
    input  logic [NUM_HEX*32-1:0] i_hex_word,
    output logic [NUM_HEX*7-1:0]  o_hex,
    input  logic [NUM_LEDR-1:0]   i_ledr,
    output logic [NUM_LEDR-1:0]   o_ledr,
    input  logic [NUM_LEDG-1:0]   i_ledg,
    output logic [NUM_LEDG-1:0]   o_ledg,
    input  logic                  i_lcd_valid,
    input  logic                  i_lcd_rs,
    input  logic [7:0]            i_lcd_byte,
    output logic                  o_lcd_ready,
    input  logic                  i_lcd_on,
    output logic [7:0]            o_lcd_data,
    output logic                  o_lcd_rs,
    output logic                  o_lcd_rw,
    output logic                  o_lcd_en,
    output logic                  o_lcd_on,
    output logic                  o_lcd_busy,
    output lcd_state_e            o_lcd_state
);

    localparam int PH_MAX = (LCD_SETUP_CYC > LCD_EN_CYC)
        ? ((LCD_SETUP_CYC > LCD_HOLD_CYC) ? LCD_SETUP_CYC : LCD_HOLD_CYC)
        : ((LCD_EN_CYC > LCD_HOLD_CYC) ? LCD_EN_CYC : LCD_HOLD_CYC);
    localparam int PH_W = $clog2(PH_MAX + 1);
    localparam int DB_W = $clog2(DB_CYC);

    localparam logic [PH_W-1:0] SETUP_LAST = PH_W'(LCD_SETUP_CYC - 1);
    localparam logic [PH_W-1:0] EN_LAST    = PH_W'(LCD_EN_CYC - 1);
    localparam logic [PH_W-1:0] HOLD_LAST  = PH_W'(LCD_HOLD_CYC - 1);
    localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DB_CYC - 1);

    lcd_state_e            state_q, state_d;
    logic [PH_W-1:0]       ph_q, ph_d;
    logic [7:0]            lcd_data_q, lcd_data_d;
    logic                  lcd_rs_q, lcd_rs_d;
    logic                  lcd_on_q, lcd_on_d;
    logic [NUM_HEX*7-1:0]  hex_q, hex_d;
    logic [NUM_LEDR-1:0]   ledr_q, ledr_d;
    logic [NUM_LEDG-1:0]   ledg_q, ledg_d;
    logic [NUM_SW-1:0]     sw_meta_q, sw_meta_d;
    logic [NUM_SW-1:0]     sw_sync_q, sw_sync_d;
    logic [NUM_SW-1:0]     sw_prev_q, sw_prev_d;
    logic [NUM_SW-1:0]     sw_db_q, sw_db_d;
    logic [DB_W-1:0]       db_cnt_q, db_cnt_d;
    logic                  db_tick;
    logic [NUM_SW-1:0]     sw_stable;
    logic                  lcd_accept;
    logic [6:0]            dec_seg [NUM_HEX];

    assign o_lcd_ready = (state_q == IDLE) && !i_reset;
    assign lcd_accept  = i_lcd_valid && o_lcd_ready;

    // One decoder per channel; bits 29:7 of each word carry nothing.
    for (genvar k = 0; k < NUM_HEX; k++) begin : g_hex
        hex_seg_decode u_dec (
            .i_nibble (i_hex_word[32*k +: 4]),
            .o_seg    (dec_seg[k])
        );
        logic hex_unused;
        assign hex_unused = ^i_hex_word[32*k+7 +: 23];
    end

    // Per-channel segment select: blank beats decode beats raw.
    always_comb begin
        hex_d = hex_q;
        for (int k = 0; k < NUM_HEX; k++) begin
            if (i_hex_word[32*k+HEX_BLANK_BIT]) begin
                hex_d[7*k +: 7] = SEG_BLANK;
            end else if (i_hex_word[32*k+HEX_DECODE_BIT]) begin
                hex_d[7*k +: 7] = dec_seg[k];
            end else begin
                hex_d[7*k +: 7] = i_hex_word[32*k +: 7];
            end
        end
    end

    // LED and LCD power registers are plain copies of their requests.
    always_comb begin
        ledr_d   = i_ledr;
        ledg_d   = i_ledg;
        lcd_on_d = i_lcd_on;
    end

    // Synchroniser, shared sample tick, and agree-on-two-ticks debounce.
    always_comb begin
        sw_meta_d = i_sw_raw;
        sw_sync_d = sw_meta_q;
        db_tick   = (db_cnt_q == DB_LAST);
        db_cnt_d  = db_tick ? '0 : db_cnt_q + DB_W'(1);
        sw_stable = ~(sw_sync_q ^ sw_prev_q);
        sw_prev_d = sw_prev_q;
        sw_db_d   = sw_db_q;
        if (db_tick) begin
            sw_prev_d = sw_sync_q;
            sw_db_d   = (sw_sync_q & sw_stable) | (sw_db_q & ~sw_stable);
        end
    end

    // LCD sequencer next state; phase counter restarts on every state change.
    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q + PH_W'(1);
        lcd_data_d = lcd_data_q;
        lcd_rs_d   = lcd_rs_q;
        case (state_q)
            IDLE: begin
                ph_d = '0;
                if (lcd_accept) begin
                    state_d    = SETUP;
                    lcd_data_d = i_lcd_byte;
                    lcd_rs_d   = i_lcd_rs;
                end
            end
            SETUP: begin
                if (ph_q == SETUP_LAST) begin
                    state_d = EN_HI;
                    ph_d    = '0;
                end
            end
            EN_HI: begin
                if (ph_q == EN_LAST) begin
                    state_d = HOLD;
                    ph_d    = '0;
                end
            end
            HOLD: begin
                if (ph_q == HOLD_LAST) begin
                    state_d = IDLE;
                    ph_d    = '0;
                end
            end
            default: begin
                state_d = IDLE;
                ph_d    = '0;
            end
        endcase
    end

    // All state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= IDLE;
            ph_q       <= '0;
            lcd_data_q <= '0;
            lcd_rs_q   <= 1'b0;
            lcd_on_q   <= 1'b0;
            hex_q      <= {NUM_HEX{SEG_BLANK}};
            ledr_q     <= '0;
            ledg_q     <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            sw_prev_q  <= '0;
            sw_db_q    <= '0;
            db_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            lcd_data_q <= lcd_data_d;
            lcd_rs_q   <= lcd_rs_d;
            lcd_on_q   <= lcd_on_d;
            hex_q      <= hex_d;
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            sw_prev_q  <= sw_prev_d;
            sw_db_q    <= sw_db_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    assign o_hex       = hex_q;
    assign o_ledr      = ledr_q;
    assign o_ledg      = ledg_q;
    assign o_sw_db     = sw_db_q;
    assign o_lcd_data  = lcd_data_q;
    assign o_lcd_rs    = lcd_rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_en    = (state_q == EN_HI);
    assign o_lcd_on    = lcd_on_q;
    assign o_lcd_busy  = (state_q != IDLE);
    assign o_lcd_state = state_q;

endmodule
